// File: rtl/audio_codec_pkg.sv
// Shared codec constants and the ADC receiver state type.
package audio_codec_pkg;

    localparam int REF_CLK     = 18432000;
    localparam int SAMPLE_RATE = 48000;
    localparam int DATA_WIDTH  = 16;
    localparam int CHANNEL_NUM = 2;

    // Half-period of BCK in reference clocks; the codec BCK runs at 12 clocks per bit.
    localparam int BCK_DIV_TERM = REF_CLK / (SAMPLE_RATE * DATA_WIDTH * CHANNEL_NUM * 2);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser with rise/fall/any-edge pulses on the synchronised level.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic iCLK_18_4,
    input  logic iRST_N,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic any_edge
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [STAGES:0]   fill_q;
    logic              primed;

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
            fill_q <= {fill_q[STAGES-1:0], 1'b1};
        end
    end

    // Edges are suppressed until the chain holds real pin samples, so a pin
    // sitting high across reset release never looks like a transition.
    assign primed   = fill_q[STAGES];
    assign level    = sync_q[STAGES-1];
    assign rise     = primed &  level & ~prev_q;
    assign fall     = primed & ~level &  prev_q;
    assign any_edge = primed & (level ^ prev_q);

endmodule

// File: rtl/adio_adc_rx.sv
// Codec ADCDAT deserialiser: left-justified MSB-first stereo words to parallel samples.
module adio_adc_rx
    import audio_codec_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int SYNC_STAGES     = 2,
    parameter bit LRCK_LEFT_LEVEL = 1'b1
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST_N,
    input  logic                  iEnable,
    input  logic                  iAUD_BCK,
    input  logic                  iAUD_LRCK,
    input  logic                  iAUD_ADCDAT,
    input  logic                  iErr_Clr,
    output logic [DATA_WIDTH-1:0] oLeft,
    output logic [DATA_WIDTH-1:0] oRight,
    output logic                  oSample_Valid,
    output logic                  oLocked,
    output logic                  oFrame_Err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

    logic bck_rise, bck_level_unused, bck_fall_unused, bck_any_unused;
    logic lrck_lvl, lrck_edge, lrck_rise_unused, lrck_fall_unused;
    logic data_s, data_rise_unused, data_fall_unused, data_any_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_bck (
        .iCLK_18_4 (iCLK_18_4),
        .iRST_N    (iRST_N),
        .din       (iAUD_BCK),
        .level     (bck_level_unused),
        .rise      (bck_rise),
        .fall      (bck_fall_unused),
        .any_edge  (bck_any_unused)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_lrck (
        .iCLK_18_4 (iCLK_18_4),
        .iRST_N    (iRST_N),
        .din       (iAUD_LRCK),
        .level     (lrck_lvl),
        .rise      (lrck_rise_unused),
        .fall      (lrck_fall_unused),
        .any_edge  (lrck_edge)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_data (
        .iCLK_18_4 (iCLK_18_4),
        .iRST_N    (iRST_N),
        .din       (iAUD_ADCDAT),
        .level     (data_s),
        .rise      (data_rise_unused),
        .fall      (data_fall_unused),
        .any_edge  (data_any_unused)
    );

    rx_state_t             state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] left_shadow;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  left_ok;
    logic                  cnt_full;
    logic                  err_set;

    always_comb begin
        cnt_full = (bit_cnt == CNT_FULL);
        err_set  = 1'b0;
        if (iEnable && lrck_edge) begin
            if (state == LEFT)
                err_set = !cnt_full;
            else if (state == RIGHT)
                err_set = !(cnt_full && left_ok);
        end
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            state         <= HUNT;
            shift_reg     <= '0;
            left_shadow   <= '0;
            bit_cnt       <= '0;
            left_ok       <= 1'b0;
            oLeft         <= '0;
            oRight        <= '0;
            oSample_Valid <= 1'b0;
            oLocked       <= 1'b0;
            oFrame_Err    <= 1'b0;
        end else begin
            oSample_Valid <= 1'b0;
            // A new error outranks a simultaneous clear.
            oFrame_Err    <= err_set | (oFrame_Err & ~iErr_Clr);

            if (!iEnable) begin
                state   <= HUNT;
                oLocked <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    HUNT: begin
                        if (lrck_edge && (lrck_lvl == LRCK_LEFT_LEVEL)) begin
                            state   <= LEFT;
                            oLocked <= 1'b1;
                        end
                    end
                    LEFT: begin
                        if (lrck_edge) begin
                            state   <= RIGHT;
                            left_ok <= cnt_full;
                            if (cnt_full)
                                left_shadow <= shift_reg;
                        end
                    end
                    RIGHT: begin
                        if (lrck_edge) begin
                            state <= LEFT;
                            if (cnt_full && left_ok) begin
                                oLeft         <= left_shadow;
                                oRight        <= shift_reg;
                                oSample_Valid <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state   <= HUNT;
                        oLocked <= 1'b0;
                    end
                endcase

                // A BCK rise coincident with the word boundary is the new word's MSB.
                if (lrck_edge) begin
                    bit_cnt   <= bck_rise ? CNT_W'(1) : '0;
                    shift_reg <= bck_rise ? {{(DATA_WIDTH-1){1'b0}}, data_s} : '0;
                end else if (bck_rise && !cnt_full) begin
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                    shift_reg <= {shift_reg[DATA_WIDTH-2:0], data_s};
                end
            end
        end
    end

endmodule

// File: tb/tb_adio_adc_rx.sv
// Directed bench for adio_adc_rx: ideal frames, short word, enable drop, async reset.
module tb_adio_adc_rx;

    logic        iCLK_18_4 = 1'b0;
    logic        iRST_N;
    logic        iEnable;
    logic        iAUD_BCK;
    logic        iAUD_LRCK;
    logic        iAUD_ADCDAT;
    logic        iErr_Clr;
    logic [15:0] oLeft;
    logic [15:0] oRight;
    logic        oSample_Valid;
    logic        oLocked;
    logic        oFrame_Err;

    always #5 iCLK_18_4 = ~iCLK_18_4;

    adio_adc_rx #(
        .DATA_WIDTH      (16),
        .SYNC_STAGES     (2),
        .LRCK_LEFT_LEVEL (1'b1)
    ) dut (
        .iCLK_18_4     (iCLK_18_4),
        .iRST_N        (iRST_N),
        .iEnable       (iEnable),
        .iAUD_BCK      (iAUD_BCK),
        .iAUD_LRCK     (iAUD_LRCK),
        .iAUD_ADCDAT   (iAUD_ADCDAT),
        .iErr_Clr      (iErr_Clr),
        .oLeft         (oLeft),
        .oRight        (oRight),
        .oSample_Valid (oSample_Valid),
        .oLocked       (oLocked),
        .oFrame_Err    (oFrame_Err)
    );

    int checks = 0;
    int errors = 0;
    int pcnt = 0;
    int chg_pc = 0;
    int prev_pc = 0;
    int vcnt = 0;
    int last_lat = 0;
    int last_per = 0;
    int base;
    logic [15:0] last_l = '0;
    logic [15:0] last_r = '0;

    always @(posedge iCLK_18_4) pcnt <= pcnt + 1;

    always @(negedge iCLK_18_4) begin
        if (oSample_Valid === 1'b1) begin
            vcnt     = vcnt + 1;
            last_l   = oLeft;
            last_r   = oRight;
            last_lat = pcnt - chg_pc;
            last_per = pcnt - prev_pc;
            prev_pc  = pcnt;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame position p: 0..191 left half (LRCK=1), 192..383 right half.
    // BCK falls at p%12==0 (data/LRCK change) and rises at p%12==6.
    task automatic drive(input logic [15:0] l, input logic [15:0] r,
                         input bit short_r, input int p0, input int p1);
        int   ph;
        int   b;
        logic lr;
        for (int p = p0; p < p1; p++) begin
            @(negedge iCLK_18_4);
            ph = p % 12;
            b  = (p % 192) / 12;
            lr = (p < 192);
            iAUD_BCK = (ph >= 6);
            if (short_r && !lr && b >= 12)
                iAUD_BCK = 1'b0;
            iAUD_ADCDAT = lr ? l[15-b] : r[15-b];
            if (lr != iAUD_LRCK)
                chg_pc = pcnt;
            iAUD_LRCK = lr;
        end
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r, input bit short_r);
        drive(l, r, short_r, 0, 384);
    endtask

    initial begin
        iRST_N      = 1'b0;
        iEnable     = 1'b1;
        iAUD_BCK    = 1'b0;
        iAUD_LRCK   = 1'b0;
        iAUD_ADCDAT = 1'b0;
        iErr_Clr    = 1'b0;
        repeat (4) @(negedge iCLK_18_4);
        chk("rst_left",   oLeft,         0);
        chk("rst_right",  oRight,        0);
        chk("rst_valid",  oSample_Valid, 0);
        chk("rst_locked", oLocked,       0);
        chk("rst_err",    oFrame_Err,    0);
        iRST_N = 1'b1;
        repeat (20) @(negedge iCLK_18_4);
        chk("idle_locked", oLocked, 0);

        // Ideal frames; each pair appears just after the next frame starts.
        send(16'hA5C3, 16'h1234, 0);
        send(16'hA5C3, 16'h1234, 0);
        send(16'hA5C3, 16'h1234, 0);
        send(16'h8000, 16'h7FFF, 0);
        chk("ideal_count",  vcnt,     3);
        chk("ideal_left",   last_l,   16'hA5C3);
        chk("ideal_right",  last_r,   16'h1234);
        chk("ideal_lat",    last_lat, 3);
        chk("ideal_period", last_per, 384);
        chk("ideal_err",    oFrame_Err, 0);

        send(16'h0000, 16'hFFFF, 0);
        chk("ext1_count", vcnt,   4);
        chk("ext1_left",  last_l, 16'h8000);
        chk("ext1_right", last_r, 16'h7FFF);
        send(16'h1111, 16'h2222, 0);
        chk("ext2_left",  last_l, 16'h0000);
        chk("ext2_right", last_r, 16'hFFFF);

        // Right half with only 12 BCK rises.
        send(16'hAAAA, 16'h5555, 1);
        send(16'h3C3C, 16'hC3C3, 0);
        chk("short_count", vcnt,       6);
        chk("short_err",   oFrame_Err, 1);
        chk("short_prev",  last_l,     16'h1111);
        send(16'h0F0F, 16'hF0F0, 0);
        chk("after_short_count", vcnt,       7);
        chk("after_short_left",  last_l,     16'h3C3C);
        chk("after_short_right", last_r,     16'hC3C3);
        chk("after_short_err",   oFrame_Err, 1);
        @(negedge iCLK_18_4);
        iErr_Clr = 1'b1;
        @(negedge iCLK_18_4);
        iErr_Clr = 1'b0;
        chk("err_clr", oFrame_Err, 0);

        // Enable dropped mid-right word for 500 clocks.
        drive(16'hABCD, 16'h4321, 0, 0, 250);
        chk("pre_drop_count", vcnt, 8);
        iEnable = 1'b0;
        drive(16'hABCD, 16'h4321, 0, 250, 251);
        chk("drop_locked", oLocked, 0);
        chk("drop_left",   oLeft,   16'h0F0F);
        chk("drop_right",  oRight,  16'hF0F0);
        drive(16'hABCD, 16'h4321, 0, 251, 384);
        drive(16'h9999, 16'h6666, 0, 0, 366);
        chk("dis_count",  vcnt,    8);
        chk("dis_locked", oLocked, 0);
        chk("dis_hold",   oLeft,   16'h0F0F);
        iEnable = 1'b1;
        drive(16'h9999, 16'h6666, 0, 366, 384);
        chk("rehunt_locked", oLocked, 0);
        send(16'hDEAD, 16'hBEEF, 0);
        chk("relock_locked", oLocked, 1);
        chk("relock_count",  vcnt,    8);
        drive(16'h5A5A, 16'hA5A5, 0, 0, 10);
        chk("relock_vcount", vcnt,   9);
        chk("relock_left",   last_l, 16'hDEAD);
        chk("relock_right",  last_r, 16'hBEEF);

        // Async reset mid-left word, released still inside the left word.
        drive(16'h5A5A, 16'hA5A5, 0, 10, 100);
        #2 iRST_N = 1'b0;
        #1;
        chk("arst_left",   oLeft,         0);
        chk("arst_right",  oRight,        0);
        chk("arst_valid",  oSample_Valid, 0);
        chk("arst_locked", oLocked,       0);
        chk("arst_err",    oFrame_Err,    0);
        base = vcnt;
        drive(16'h5A5A, 16'hA5A5, 0, 100, 110);
        iRST_N = 1'b1;
        drive(16'h5A5A, 16'hA5A5, 0, 110, 384);
        chk("partial_count",  vcnt - base, 0);
        chk("partial_err",    oFrame_Err,  0);
        chk("partial_locked", oLocked,     0);
        send(16'h1357, 16'h2468, 0);
        chk("resume_locked", oLocked,     1);
        chk("resume_none",   vcnt - base, 0);
        drive(16'h0001, 16'h0002, 0, 0, 10);
        chk("resume_count", vcnt - base, 1);
        chk("resume_left",  last_l,      16'h1357);
        chk("resume_right", last_r,      16'h2468);
        chk("resume_lat",   last_lat,    3);
        chk("resume_err",   oFrame_Err,  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
